// File: rtl/dmem_lsu_if.sv
// Datapath <-> load/store unit bus: request address/data/size going in, load result and status coming back.
interface dmem_lsu_if;
  logic        MemWrite;
  logic        MemRead;
  logic [2:0]  funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        AccessErr;

  modport master (
    output MemWrite, MemRead, funct3, ALUResult, WriteData,
    input  ReadData, Stall, AccessErr
  );

  modport slave (
    input  MemWrite, MemRead, funct3, ALUResult, WriteData,
    output ReadData, Stall, AccessErr
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit with embedded word RAM: single-cycle byte-enabled stores,
// two-cycle loads (IDLE -> RESP) with stall, lane extraction and extension.
module dmem_lsu #(
  parameter int DEPTH = 256
) (
  input  logic      clk,
  input  logic      reset,
  dmem_lsu_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata_q;
  logic [4:0]  r_ctl_q;

  logic [IDX_W-1:0] w_idx;
  logic             w_req;
  logic             w_f3_legal;
  logic             w_misalign;
  logic             w_err;
  logic             w_store_en;
  logic             w_load_acc;
  logic             w_stall;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_rdata;

  assign w_idx = bus.ALUResult[IDX_W+1:2];
  assign w_req = bus.MemRead | bus.MemWrite;

  // A simultaneous read+write is a store, so store legality rules apply.
  always_comb begin
    w_f3_legal = 1'b0;
    w_misalign = 1'b0;
    if (bus.MemWrite)
      w_f3_legal = bus.funct3 inside {3'b000, 3'b001, 3'b010};
    else
      w_f3_legal = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (bus.funct3[1:0])
      2'b01:   w_misalign = bus.ALUResult[0];
      2'b10:   w_misalign = |bus.ALUResult[1:0];
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_err      = reset && w_req && (r_state == S_IDLE) && (!w_f3_legal || w_misalign);
  assign w_store_en = reset && bus.MemWrite && (r_state == S_IDLE) && !w_err;

  // Per-lane byte enable and lane-replicated store data.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        case (bus.funct3[1:0])
          2'b00: begin
            w_be[gi]             = (bus.ALUResult[1:0] == 2'(gi));
            w_wdata[gi*8 +: 8]   = bus.WriteData[7:0];
          end
          2'b01: begin
            w_be[gi]             = (bus.ALUResult[1] == 1'(gi / 2));
            w_wdata[gi*8 +: 8]   = bus.WriteData[(gi % 2)*8 +: 8];
          end
          default: begin
            w_be[gi]             = 1'b1;
            w_wdata[gi*8 +: 8]   = bus.WriteData[gi*8 +: 8];
          end
        endcase
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_load_acc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (reset && bus.MemRead && !bus.MemWrite && !w_err) begin
          w_stall      = 1'b1;
          w_load_acc   = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rdata_q <= '0;
      r_ctl_q   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load_acc) begin
        r_rdata_q <= r_mem[w_idx];
        r_ctl_q   <= {bus.ALUResult[1:0], bus.funct3};
      end
    end
  end

  // Response path depends only on latched control, never on live inputs.
  always_comb begin
    case (r_ctl_q[4:3])
      2'd0:    w_byte = r_rdata_q[7:0];
      2'd1:    w_byte = r_rdata_q[15:8];
      2'd2:    w_byte = r_rdata_q[23:16];
      default: w_byte = r_rdata_q[31:24];
    endcase
    w_half  = r_ctl_q[4] ? r_rdata_q[31:16] : r_rdata_q[15:0];
    w_rdata = '0;
    if (r_state == S_RESP) begin
      case (r_ctl_q[2:0])
        3'b000:  w_rdata = {{24{w_byte[7]}}, w_byte};
        3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
        3'b010:  w_rdata = r_rdata_q;
        3'b100:  w_rdata = {24'd0, w_byte};
        3'b101:  w_rdata = {16'd0, w_half};
        default: w_rdata = '0;
      endcase
    end
  end

  assign bus.ReadData  = w_rdata;
  assign bus.Stall     = w_stall;
  assign bus.AccessErr = w_err;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed plus random check of dmem_lsu against a byte-array reference memory.
module tb_dmem_lsu;
  localparam int DEPTH = 256;
  localparam int BYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] ram_b [BYTES];

  dmem_lsu_if bus();

  dmem_lsu #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_err(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int n;
    if (st) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    n = acc_size(f3);
    return !legal || ((a % n) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n, base, sh;
    n    = acc_size(f3);
    base = int'(a % BYTES);
    v    = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ram_b[base + i]) << (8 * i));
    if (!f3[2] && n < 4) begin
      sh = 32 - 8 * n;
      v  = 32'($signed(v << sh) >>> sh);
    end
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n, base;
    n    = acc_size(f3);
    base = int'(a % BYTES);
    for (int i = 0; i < n; i++) ram_b[base + i] = wd[8*i +: 8];
  endtask

  task automatic idle_inputs();
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.funct3    = 3'b000;
    bus.ALUResult = 32'd0;
    bus.WriteData = 32'd0;
  endtask

  // One datapath instruction; returns the value seen on ReadData (0 when no load response).
  task automatic access(input bit we, input bit re, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit quiet, output logic [31:0] got);
    bit          err, stl;
    logic [31:0] exp;
    @(negedge clk);
    bus.MemWrite  = we;
    bus.MemRead   = re;
    bus.funct3    = f3;
    bus.ALUResult = a;
    bus.WriteData = wd;
    #1;
    err = (we || re) && model_err(we, f3, a);
    stl = re && !we && !err;
    chk("access_err", 32'(bus.AccessErr), 32'(err));
    chk("stall_req", 32'(bus.Stall), 32'(stl));
    if (!stl) chk("rdata_zero_idle", bus.ReadData, 32'd0);
    got = 32'd0;
    @(posedge clk);
    #1;
    if (stl) begin
      exp = model_load(f3, a);
      got = bus.ReadData;
      chk("stall_resp", 32'(bus.Stall), 32'd0);
      chk("load_data", bus.ReadData, exp);
      bus.ALUResult = $urandom;
      bus.funct3    = 3'($urandom);
      #1;
      chk("load_data_hold", bus.ReadData, exp);
      chk("err_in_resp", 32'(bus.AccessErr), 32'd0);
      idle_inputs();
      @(posedge clk);
      #1;
      chk("rdata_after_resp", bus.ReadData, 32'd0);
    end else begin
      if (we && !err) model_store(f3, a, wd);
      idle_inputs();
    end
    if (!quiet)
      $display("txn we=%0d re=%0d f3=%0d addr=%h wdata=%h err=%0d rdata=%h",
               we, re, f3, a, wd, err, got);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    logic [2:0]  f3;
    int          kind;

    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", 32'(bus.Stall), 32'd0);
    chk("reset_rdata", bus.ReadData, 32'd0);
    chk("reset_err", 32'(bus.AccessErr), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int w = 0; w < DEPTH; w++) access(1'b1, 1'b0, 3'b010, 32'(w * 4), 32'd0, 1'b1, got);

    // Word store/load round trip
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, got);
    access(1'b0, 1'b1, 3'b010, 32'h10, 32'd0, 1'b0, got);
    chk("tp_lw_deadbeef", got, 32'hDEADBEEF);

    // Byte lane and extension
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h00000000, 1'b0, got);
    access(1'b1, 1'b0, 3'b000, 32'h13, 32'h00000080, 1'b0, got);
    access(1'b0, 1'b1, 3'b000, 32'h13, 32'd0, 1'b0, got);
    chk("tp_lb", got, 32'hFFFFFF80);
    access(1'b0, 1'b1, 3'b100, 32'h13, 32'd0, 1'b0, got);
    chk("tp_lbu", got, 32'h00000080);
    access(1'b0, 1'b1, 3'b010, 32'h10, 32'd0, 1'b0, got);
    chk("tp_lw_byte", got, 32'h80000000);

    // Halfword lanes
    access(1'b1, 1'b0, 3'b010, 32'h20, 32'h00000000, 1'b0, got);
    access(1'b1, 1'b0, 3'b001, 32'h22, 32'h00001234, 1'b0, got);
    access(1'b0, 1'b1, 3'b001, 32'h22, 32'd0, 1'b0, got);
    chk("tp_lh", got, 32'h00001234);
    access(1'b0, 1'b1, 3'b101, 32'h20, 32'd0, 1'b0, got);
    chk("tp_lhu_low", got, 32'h00000000);

    // Misaligned / illegal accesses leave memory untouched
    access(1'b0, 1'b1, 3'b010, 32'h11, 32'd0, 1'b0, got);
    access(1'b1, 1'b0, 3'b001, 32'h03, 32'hFFFF, 1'b0, got);
    access(1'b1, 1'b0, 3'b010, 32'h12, 32'h11111111, 1'b0, got);
    access(1'b0, 1'b1, 3'b010, 32'h10, 32'd0, 1'b0, got);
    chk("tp_lw_unchanged", got, 32'h80000000);
    access(1'b0, 1'b1, 3'b011, 32'h10, 32'd0, 1'b0, got);
    access(1'b1, 1'b0, 3'b100, 32'h10, 32'd0, 1'b0, got);

    // Address wrap
    access(1'b1, 1'b0, 3'b010, 32'(BYTES + 4), 32'hA5A5A5A5, 1'b0, got);
    access(1'b0, 1'b1, 3'b010, 32'h4, 32'd0, 1'b0, got);
    chk("tp_wrap", got, 32'hA5A5A5A5);

    // Read+write together behaves as a store
    access(1'b1, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 1'b0, got);
    access(1'b0, 1'b1, 3'b010, 32'h30, 32'd0, 1'b0, got);
    chk("tp_rw_store", got, 32'hCAFEF00D);

    // Reset during RESP abandons the load, RAM survives
    access(1'b1, 1'b0, 3'b010, 32'h40, 32'h5A5A1234, 1'b0, got);
    @(negedge clk);
    bus.MemRead   = 1'b1;
    bus.funct3    = 3'b010;
    bus.ALUResult = 32'h40;
    #1;
    chk("rst_pre_stall", 32'(bus.Stall), 32'd1);
    @(posedge clk);
    #1;
    chk("rst_pre_data", bus.ReadData, 32'h5A5A1234);
    reset = 1'b0;
    #1;
    chk("rst_stall", 32'(bus.Stall), 32'd0);
    chk("rst_rdata", bus.ReadData, 32'd0);
    chk("rst_err", 32'(bus.AccessErr), 32'd0);
    bus.ALUResult = 32'h41;
    #1;
    chk("rst_err_misaligned", 32'(bus.AccessErr), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_rdata", bus.ReadData, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    access(1'b0, 1'b1, 3'b010, 32'h40, 32'd0, 1'b0, got);
    chk("rst_ram_kept", got, 32'h5A5A1234);

    // Random traffic against the byte-array model
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 9));
      f3   = 3'($urandom);
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(acc_size(f3) - 1);
      if (kind <= 3)      access(1'b0, 1'b1, f3, a, $urandom, 1'b0, got);
      else if (kind <= 7) access(1'b1, 1'b0, f3, a, $urandom, 1'b0, got);
      else if (kind == 8) access(1'b1, 1'b1, f3, a, $urandom, 1'b0, got);
      else                access(1'b0, 1'b0, f3, a, $urandom, 1'b0, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
